// File: rtl/fifo_stream_adapter.sv
// fifo_stream_adapter
//   Bridges a first-word-fall-through-less FIFO read port (data one cycle
//   after rd_en) to a valid/ready output stream. A 2-entry in-order buffer
//   plus one in-flight flag lets the adapter issue pops ahead of demand and
//   sustain one beat per cycle while never overrunning its own storage.
//
//   Optional feature: define FIFO_STREAM_RD_CNT_EN to enable the rd_cnt
//   beat counter; otherwise rd_cnt is tied to zero.
//
// Ports
//   clk      : clock, all state changes on the rising edge
//   rst      : asynchronous, active-high reset
//   empty    : FIFO empty flag
//   data_out : FIFO read data, valid the cycle after an accepted rd_en
//   rd_en    : FIFO pop request
//   flush    : synchronous discard of buffered and in-flight words
//   m_valid  : output stream word valid (registered)
//   m_data   : output stream word (registered buffer head)
//   m_ready  : downstream accept
//   rd_cnt   : completed-beat counter (zero unless FIFO_STREAM_RD_CNT_EN)
module fifo_stream_adapter #(
    parameter int FIFO_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  empty,
    input  logic [FIFO_WIDTH-1:0] data_out,
    output logic                  rd_en,
    input  logic                  flush,
    output logic                  m_valid,
    output logic [FIFO_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic [15:0]           rd_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_t;

    occ_t                  occ;
    logic                  inflight;
    logic [FIFO_WIDTH-1:0] tail;

    logic                  beat;
    logic                  capture;
    logic [1:0]            total;
    logic                  credit;

    // Credit: buffered + in-flight words may never exceed two after an edge.
    // At exactly two, a pop is only safe when a beat frees a slot this edge.
    always_comb begin
        beat    = m_valid && m_ready;
        capture = inflight;
        total   = 2'(occ) + {1'b0, inflight};
        credit  = (total < 2'd2) || ((total == 2'd2) && beat);
        rd_en   = !empty && !flush && !rst && credit;
    end

    // m_data is the buffer head; tail holds the second entry when occ == TWO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ      <= EMPTY;
            inflight <= 1'b0;
            m_valid  <= 1'b0;
            m_data   <= '0;
            tail     <= '0;
        end else begin
            inflight <= rd_en;
            if (flush) begin
                occ     <= EMPTY;
                m_valid <= 1'b0;
            end else begin
                case (occ)
                    EMPTY: begin
                        if (capture) begin
                            m_data  <= data_out;
                            occ     <= ONE;
                            m_valid <= 1'b1;
                        end
                    end
                    ONE: begin
                        if (beat && capture) begin
                            m_data <= data_out;
                        end else if (beat) begin
                            occ     <= EMPTY;
                            m_valid <= 1'b0;
                        end else if (capture) begin
                            tail <= data_out;
                            occ  <= TWO;
                        end
                    end
                    TWO: begin
                        // Capture without a beat cannot occur here: the
                        // credit rule withheld the pop that would feed it.
                        if (beat) begin
                            m_data <= tail;
                            if (capture) begin
                                tail <= data_out;
                            end else begin
                                occ <= ONE;
                            end
                        end
                    end
                    default: begin
                        occ     <= EMPTY;
                        m_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef FIFO_STREAM_RD_CNT_EN
    // Counts every completed beat, including one coincident with flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt <= '0;
        end else if (beat) begin
            rd_cnt <= rd_cnt + 16'd1;
        end
    end
`else
    assign rd_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_stream_adapter.sv
// Testbench for fifo_stream_adapter: a behavioural FIFO feeds the DUT,
// every popped word is pushed to an expected-stream queue, and a separate
// monitor compares each presented output word against that queue.
module tb_fifo_stream_adapter;

    localparam int W = 32;
`ifdef FIFO_STREAM_RD_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic         clk      = 1'b0;
    logic         rst      = 1'b1;
    logic         empty    = 1'b1;
    logic         flush    = 1'b0;
    logic         m_ready  = 1'b0;
    logic [W-1:0] data_out = '0;
    logic         rd_en;
    logic         m_valid;
    logic [W-1:0] m_data;
    logic [15:0]  rd_cnt;

    fifo_stream_adapter #(.FIFO_WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .empty    (empty),
        .data_out (data_out),
        .rd_en    (rd_en),
        .flush    (flush),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .m_ready  (m_ready),
        .rd_cnt   (rd_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        int unsigned  c;
    } exp_t;

    int unsigned  n_checks = 0;
    int unsigned  n_fail   = 0;
    int unsigned  cyc      = 0;
    int unsigned  pops     = 0;
    int unsigned  beats    = 0;
    logic [15:0]  cnt_model = '0;
    logic [W-1:0] fifo_q[$];
    exp_t         exp_q[$];

    // stimulus controls applied at each falling edge
    logic         rst_req   = 1'b1;
    logic         flush_req = 1'b0;
    int           ready_req = 1;   // 0, 1, or 2 = random
    int           gate_mode = 0;   // 0 none, 1 alternate, 2 random
    logic         gate      = 1'b0;
    logic         last_rd   = 1'b0;
    logic [W-1:0] pending   = '0;
    logic         have_pending = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [15:0] exp_cnt();
        return CNT_EN ? cnt_model : 16'h0000;
    endfunction

    // One clock cycle: drive inputs at the falling edge, then model the FIFO.
    task automatic step();
        @(negedge clk);
        rst   = rst_req;
        flush = flush_req;
        case (gate_mode)
            0:       gate = 1'b0;
            1:       gate = ~gate;
            default: gate = ($urandom_range(0, 3) == 0);
        endcase
        m_ready  = (ready_req == 2) ? ($urandom_range(0, 1) == 1) : (ready_req == 1);
        empty    = (fifo_q.size() == 0) || gate;
        data_out = have_pending ? pending : $urandom;
        have_pending = 1'b0;
        #1;
        last_rd = rd_en;
        chk("rd_en_while_empty", 32'(rd_en & empty), 32'd0);
        chk("rd_en_while_flush_rst", 32'(rd_en & (flush | rst)), 32'd0);
        if (rd_en && fifo_q.size() != 0) begin
            pending      = fifo_q.pop_front();
            have_pending = 1'b1;
            exp_q.push_back('{d: pending, c: cyc});
            pops++;
        end
    endtask

    task automatic drain();
        int unsigned k;
        ready_req = 1;
        flush_req = 1'b0;
        k = 0;
        while ((fifo_q.size() != 0 || exp_q.size() != 0 || m_valid) && k < 200) begin
            step();
            k++;
        end
        n_checks++;
        if (k >= 200) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d words still expected, required 0", exp_q.size());
        end
    endtask

    // Monitor: sampled mid-cycle, well away from the rising edge.
    logic         prev_valid = 1'b0;
    logic         prev_stall = 1'b0;
    logic         prev_flush = 1'b0;
    logic [W-1:0] prev_data  = '0;

    always begin
        @(negedge clk);
        #2;
        if (rst) begin
            chk("rst_m_valid", 32'(m_valid), 32'd0);
            chk("rst_m_data", m_data, 32'd0);
            chk("rst_rd_cnt", 32'(rd_cnt), 32'd0);
            chk("rst_rd_en", 32'(rd_en), 32'd0);
            exp_q.delete();
            cnt_model  = '0;
            prev_valid = 1'b0;
            prev_stall = 1'b0;
            prev_flush = 1'b0;
        end else begin
            chk("rd_cnt", 32'(rd_cnt), 32'(exp_cnt()));
            if (prev_flush) chk("after_flush_m_valid", 32'(m_valid), 32'd0);
            if (prev_stall) begin
                chk("stall_m_valid", 32'(m_valid), 32'd1);
                chk("stall_m_data", m_data, prev_data);
            end
            if (m_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_word: got %h, required no valid word", m_data);
                end else begin
                    chk("m_data", m_data, exp_q[0].d);
                    if (!prev_valid) chk("latency", cyc - exp_q[0].c, 32'd2);
                    if (m_ready) begin
                        void'(exp_q.pop_front());
                        beats++;
                        cnt_model = cnt_model + 16'd1;
                    end
                end
            end
            if (flush) exp_q.delete();
            prev_stall = m_valid && !m_ready && !flush;
            prev_flush = flush;
            prev_valid = m_valid;
            prev_data  = m_data;
        end
    end

    initial begin
        int vc;
        int first;
        int last;
        int unsigned b0;
        int unsigned k;

        // reset
        rst_req   = 1'b1;
        ready_req = 1;
        repeat (3) step();
        chk("reset_rd_en", 32'(rd_en), 32'd0);

        // single word; first pop in the first cycle after reset release
        fifo_q.push_back(32'hA5A5_A5A5);
        pops    = 0;
        rst_req = 1'b0;
        step();
        chk("first_rd_after_reset", 32'(last_rd), 32'd1);
        vc = 0;
        repeat (8) begin
            step();
            if (m_valid) begin
                vc++;
                chk("single_data", m_data, 32'hA5A5_A5A5);
            end
        end
        chk("single_valid_cycles", 32'(vc), 32'd1);
        chk("single_pops", pops, 32'd1);
        chk("single_rd_cnt", 32'(rd_cnt), CNT_EN ? 32'd1 : 32'd0);

        // streaming 1..8 with no bubbles
        for (int i = 1; i <= 8; i++) fifo_q.push_back(W'(i));
        vc = 0; first = -1; last = -1;
        for (int i = 0; i < 16; i++) begin
            step();
            if (m_valid) begin
                vc++;
                if (first < 0) first = i;
                last = i;
            end
        end
        chk("stream_valid_cycles", 32'(vc), 32'd8);
        chk("stream_contiguous", 32'(last - first + 1), 32'd8);
        drain();

        // backpressure: 6 words, stalled 10 cycles
        ready_req = 0;
        pops = 0;
        for (int i = 1; i <= 6; i++) fifo_q.push_back(W'(i));
        repeat (10) step();
        chk("bp_pops", pops, 32'd2);
        chk("bp_m_valid", 32'(m_valid), 32'd1);
        chk("bp_m_data", m_data, 32'd1);
        drain();

        // flush with one buffered word and one in flight
        ready_req = 0;
        pops = 0;
        for (int i = 1; i <= 10; i++) fifo_q.push_back(32'h100 + 32'(i));
        repeat (6) step();
        chk("flush_setup_pops", pops, 32'd2);
        ready_req = 1;
        step();
        chk("flush_setup_pop3", pops, 32'd3);
        ready_req = 0;
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        step();
        chk("flush_m_valid", 32'(m_valid), 32'd0);
        chk("flush_rd_cnt", 32'(rd_cnt), 32'(exp_cnt()));
        ready_req = 1;
        k = 0;
        while (!m_valid && k < 10) begin
            step();
            k++;
        end
        chk("flush_next_word", m_data, 32'h104);
        drain();

        // empty toggling every cycle
        gate_mode = 1;
        for (int i = 0; i < 8; i++) fifo_q.push_back($urandom);
        drain();
        gate_mode = 0;

        // reset pulse mid-stream at word 3
        b0 = beats;
        for (int i = 1; i <= 8; i++) fifo_q.push_back(32'h200 + 32'(i));
        k = 0;
        while (beats < b0 + 2 && k < 20) begin
            step();
            k++;
        end
        chk("midrst_reached", 32'(beats >= b0 + 2), 32'd1);
        rst_req = 1'b1;
        step();
        chk("midrst_m_valid", 32'(m_valid), 32'd0);
        chk("midrst_m_data", m_data, 32'd0);
        chk("midrst_rd_en", 32'(rd_en), 32'd0);
        chk("midrst_rd_cnt", 32'(rd_cnt), 32'd0);
        step();
        rst_req = 1'b0;
        drain();

        // randomized traffic with occasional flush
        gate_mode = 2;
        ready_req = 2;
        for (int i = 0; i < 400; i++) begin
            if (fifo_q.size() < 4) fifo_q.push_back($urandom);
            flush_req = ($urandom_range(0, 39) == 0);
            step();
        end
        flush_req = 1'b0;
        gate_mode = 0;
        drain();
        chk("final_rd_cnt", 32'(rd_cnt), 32'(exp_cnt()));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
